rob_core: RTL and testbench

Reorder buffer for the out-of-order core. It allocates a tag for each issued instruction and collects writeback results by tag. It answers operand-readiness lookups from the register status file and retires instructions in program order, driving the register file's commit port. It also detects branch mispredictions at the head and broadcasts the pipeline flush that clears rename state everywhere.

---
 rtl/rob_core_if.sv | 54 +++++
 rtl/rob_core.sv | 135 +++++++++++++
 tb/tb_rob_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_core_if.sv
// Reorder buffer port bundle: issue/allocate, writeback,
// operand lookup and commit/flush signals.
interface rob_core_if #(
  parameter int TAG_W = 5
);
  logic             rdy;
  logic             alloc_en;
  logic [4:0]       alloc_rd;
  logic             alloc_is_br;
  logic             alloc_pred_taken;
  logic [TAG_W-1:0] tail;
  logic             full;
  logic             wb_en;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;
  logic             wb_taken;
  logic [31:0]      wb_pc;
  logic [TAG_W-1:0] rs1_id;
  logic [TAG_W-1:0] rs2_id;
  logic             rob_rs1_ready;
  logic             rob_rs2_ready;
  logic [31:0]      rob_rs1_value;
  logic [31:0]      rob_rs2_value;
  logic             run_upd;
  logic [4:0]       commit_rd;
  logic [31:0]      res;
  logic [TAG_W-1:0] head;
  logic             reset;
  logic [31:0]      redirect_pc;

  modport master (
    output rdy, alloc_en, alloc_rd, alloc_is_br,
    output alloc_pred_taken,
    output wb_en, wb_tag, wb_value, wb_taken, wb_pc,
    output rs1_id, rs2_id,
    input  tail, full,
    input  rob_rs1_ready, rob_rs2_ready,
    input  rob_rs1_value, rob_rs2_value,
    input  run_upd, commit_rd, res, head,
    input  reset, redirect_pc
  );

  modport slave (
    input  rdy, alloc_en, alloc_rd, alloc_is_br,
    input  alloc_pred_taken,
    input  wb_en, wb_tag, wb_value, wb_taken, wb_pc,
    input  rs1_id, rs2_id,
    output tail, full,
    output rob_rs1_ready, rob_rs2_ready,
    output rob_rs1_value, rob_rs2_value,
    output run_upd, commit_rd, res, head,
    output reset, redirect_pc
  );
endinterface

// File: rtl/rob_core.sv
// Reorder buffer: tag allocation, in-order commit, mispredict flush.
// ROB_BYPASS_EN: lookups forward a same-cycle writeback.
module rob_core #(
  parameter int ROB_SZ = 16,
  parameter int TAG_W  = 5
) (
  input logic       clk,
  input logic       rst,
  rob_core_if.slave bus
);
  localparam int CNT_W = $clog2(ROB_SZ + 1);

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  rd;
    logic        is_br;
    logic        pred;
    logic        taken;
    logic [31:0] value;
    logic [31:0] pc;
  } ent_t;

  // slot 0 exists only as a never-valid target for tag 0
  ent_t ent [ROB_SZ+1];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full;
  ent_t             he;
  logic             commit;
  logic             mispred;
  logic             do_alloc;
  logic             do_wb;
  logic [TAG_W-1:0] wi;

  function automatic logic [TAG_W-1:0] nxt(
    input logic [TAG_W-1:0] p
  );
    return (p == TAG_W'(ROB_SZ)) ? TAG_W'(1)
                                 : p + TAG_W'(1);
  endfunction

  function automatic logic [TAG_W-1:0] idx(
    input logic [TAG_W-1:0] t
  );
    return (t <= TAG_W'(ROB_SZ)) ? t : '0;
  endfunction

  function automatic logic [32:0] lookup(
    input logic [TAG_W-1:0] id
  );
    ent_t e;
    e = ent[idx(id)];
    lookup = '0;
    if (e.valid && e.ready)
      lookup = {1'b1, e.value};
`ifdef ROB_BYPASS_EN
    if (e.valid && bus.wb_en && bus.wb_tag == id)
      lookup = {1'b1, bus.wb_value};
`endif
  endfunction

  assign full    = (count == CNT_W'(ROB_SZ));
  assign he      = ent[head];
  assign commit  = bus.rdy && (count != '0)
                && he.valid && he.ready;
  assign mispred = commit && he.is_br
                && (he.taken != he.pred);

  assign wi       = idx(bus.wb_tag);
  assign do_wb    = bus.wb_en && ent[wi].valid;
  assign do_alloc = bus.alloc_en && !full;

  assign bus.tail        = tail;
  assign bus.head        = head;
  assign bus.full        = full;
  assign bus.run_upd     = commit;
  assign bus.commit_rd   = commit ? he.rd : 5'd0;
  assign bus.res         = commit ? he.value : 32'd0;
  assign bus.reset       = mispred;
  assign bus.redirect_pc = mispred ? he.pc : 32'd0;

  assign {bus.rob_rs1_ready, bus.rob_rs1_value} =
    lookup(bus.rs1_id);
  assign {bus.rob_rs2_ready, bus.rob_rs2_value} =
    lookup(bus.rs2_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= '0;
      for (int i = 0; i <= ROB_SZ; i++)
        ent[i] <= '0;
    end else if (bus.rdy) begin
      if (mispred) begin
        head  <= TAG_W'(1);
        tail  <= TAG_W'(1);
        count <= '0;
        for (int i = 0; i <= ROB_SZ; i++)
          ent[i].valid <= 1'b0;
      end else begin
        if (do_wb) begin
          ent[wi].ready <= 1'b1;
          ent[wi].value <= bus.wb_value;
          ent[wi].taken <= bus.wb_taken;
          ent[wi].pc    <= bus.wb_pc;
        end
        if (commit) begin
          ent[head].valid <= 1'b0;
          head            <= nxt(head);
        end
        // tail slot is free, so it never collides with wb/commit
        if (do_alloc) begin
          ent[tail].valid <= 1'b1;
          ent[tail].ready <= 1'b0;
          ent[tail].rd    <= bus.alloc_rd;
          ent[tail].is_br <= bus.alloc_is_br;
          ent[tail].pred  <= bus.alloc_pred_taken;
          ent[tail].taken <= 1'b0;
          ent[tail].value <= '0;
          ent[tail].pc    <= '0;
          tail            <= nxt(tail);
        end
        unique case ({do_alloc, commit})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rob_core.sv
// Testbench for rob_core: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_rob_core;
  localparam int SZ = 16;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  rob_core_if #(.TAG_W(5)) bus ();

  rob_core #(.ROB_SZ(SZ), .TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          br;
    bit          pred;
    bit          rdy_;
    logic [31:0] val;
    bit          tk;
    logic [31:0] pc;
  } ment_t;

  ment_t q[$];
  int    m_head = 1;
  int    m_tail = 1;

  task automatic chk(input string nm, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, o, e);
    end
  endtask

  function automatic void look(input int id, output bit r,
                               output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (q[i]) begin
      if (q[i].tag == id) begin
        if (BYP && bus.wb_en && int'(bus.wb_tag) == id) begin
          r = 1'b1;
          v = bus.wb_value;
        end else if (q[i].rdy_) begin
          r = 1'b1;
          v = q[i].val;
        end
      end
    end
  endfunction

  task automatic idle();
    rst                  = 1'b0;
    bus.rdy              = 1'b1;
    bus.alloc_en         = 1'b0;
    bus.alloc_rd         = '0;
    bus.alloc_is_br      = 1'b0;
    bus.alloc_pred_taken = 1'b0;
    bus.wb_en            = 1'b0;
    bus.wb_tag           = '0;
    bus.wb_value         = '0;
    bus.wb_taken         = 1'b0;
    bus.wb_pc            = '0;
    bus.rs1_id           = '0;
    bus.rs2_id           = '0;
  endtask

  // check this cycle's outputs, advance model, move to next cycle
  task automatic tick();
    bit          cm, mis, wasfull, r1, r2;
    logic [31:0] v1, v2;
    ment_t       e;
    #1;
    cm  = bus.rdy && q.size() > 0 && q[0].rdy_;
    mis = cm && q[0].br && (q[0].tk != q[0].pred);
    look(int'(bus.rs1_id), r1, v1);
    look(int'(bus.rs2_id), r2, v2);
    chk("tail", 32'(bus.tail), m_tail);
    chk("head", 32'(bus.head), m_head);
    chk("full", 32'(bus.full), 32'(q.size() == SZ));
    chk("run_upd", 32'(bus.run_upd), 32'(cm));
    chk("commit_rd", 32'(bus.commit_rd),
        cm ? 32'(q[0].rd) : 32'd0);
    chk("res", bus.res, cm ? q[0].val : 32'd0);
    chk("reset", 32'(bus.reset), 32'(mis));
    chk("redirect_pc", bus.redirect_pc,
        mis ? q[0].pc : 32'd0);
    chk("rs1_ready", 32'(bus.rob_rs1_ready), 32'(r1));
    chk("rs1_value", bus.rob_rs1_value, v1);
    chk("rs2_ready", 32'(bus.rob_rs2_ready), 32'(r2));
    chk("rs2_value", bus.rob_rs2_value, v2);
    if (rst || (bus.rdy && mis)) begin
      q.delete();
      m_head = 1;
      m_tail = 1;
    end else if (bus.rdy) begin
      wasfull = (q.size() == SZ);
      if (bus.wb_en)
        foreach (q[i])
          if (q[i].tag == int'(bus.wb_tag)) begin
            q[i].rdy_ = 1'b1;
            q[i].val  = bus.wb_value;
            q[i].tk   = bus.wb_taken;
            q[i].pc   = bus.wb_pc;
          end
      if (cm) begin
        void'(q.pop_front());
        m_head = m_head % SZ + 1;
      end
      if (bus.alloc_en && !wasfull) begin
        e.tag  = m_tail;
        e.rd   = bus.alloc_rd;
        e.br   = bus.alloc_is_br;
        e.pred = bus.alloc_pred_taken;
        e.rdy_ = 1'b0;
        e.val  = '0;
        e.tk   = 1'b0;
        e.pc   = '0;
        q.push_back(e);
        m_tail = m_tail % SZ + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc(input logic [4:0] rd, input bit br,
                       input bit pred);
    idle();
    bus.alloc_en         = 1'b1;
    bus.alloc_rd         = rd;
    bus.alloc_is_br      = br;
    bus.alloc_pred_taken = pred;
    tick();
  endtask

  task automatic wb(input int tag, input logic [31:0] v,
                    input bit tk, input logic [31:0] pc);
    idle();
    bus.wb_en    = 1'b1;
    bus.wb_tag   = 5'(tag);
    bus.wb_value = v;
    bus.wb_taken = tk;
    bus.wb_pc    = pc;
    tick();
  endtask

  task automatic do_rst();
    idle();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_head", 32'(bus.head), 32'd1);
    chk("rst_tail", 32'(bus.tail), 32'd1);

    // in-order commit
    alloc(5'd5, 1'b0, 1'b0);
    alloc(5'd6, 1'b0, 1'b0);
    alloc(5'd0, 1'b0, 1'b0);
    chk("alloc3_tail", 32'(bus.tail), 32'd4);
    wb(2, 32'h22, 1'b0, 32'h0);
    wb(1, 32'h11, 1'b0, 32'h0);
    idle(); tick();
    idle(); tick();
    idle(); tick();
    chk("tag3_waits", 32'(bus.head), 32'd3);
    wb(3, 32'h33, 1'b0, 32'h0);
    idle(); tick();

    // fill, overflow attempt, wrap
    do_rst();
    for (int i = 0; i < SZ; i++)
      alloc(5'($urandom), 1'b0, 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    alloc(5'd9, 1'b0, 1'b0);
    chk("ovf_tail", 32'(bus.tail), 32'd1);
    wb(1, 32'hCAFE, 1'b0, 32'h0);
    idle(); tick();
    chk("full_clr", 32'(bus.full), 32'd0);
    alloc(5'd7, 1'b0, 1'b0);
    chk("wrap_tail", 32'(bus.tail), 32'd2);

    // mispredict flush
    do_rst();
    alloc(5'd1, 1'b1, 1'b0);
    alloc(5'd2, 1'b0, 1'b0);
    alloc(5'd3, 1'b0, 1'b0);
    alloc(5'd4, 1'b0, 1'b0);
    wb(1, 32'h5, 1'b1, 32'h100);
    alloc(5'd8, 1'b0, 1'b0);
    chk("flush_head", 32'(bus.head), 32'd1);
    chk("flush_tail", 32'(bus.tail), 32'd1);

    // same-cycle lookup of a writeback
    do_rst();
    alloc(5'd1, 1'b0, 1'b0);
    alloc(5'd2, 1'b0, 1'b0);
    alloc(5'd3, 1'b0, 1'b0);
    idle();
    bus.wb_en    = 1'b1;
    bus.wb_tag   = 5'd3;
    bus.wb_value = 32'hABCD;
    bus.rs1_id   = 5'd3;
    tick();
    idle();
    bus.rs1_id = 5'd3;
    bus.rs2_id = 5'd1;
    tick();

    // rdy hold with a ready head
    do_rst();
    alloc(5'd12, 1'b0, 1'b0);
    wb(1, 32'h1234, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.rdy      = 1'b0;
      bus.alloc_en = 1'b1;
      bus.wb_en    = 1'b1;
      bus.wb_tag   = 5'd1;
      bus.wb_value = 32'hDEAD;
      tick();
    end
    idle(); tick();

    // reset mid-stream
    do_rst();
    for (int i = 0; i < 5; i++)
      alloc(5'(i + 1), 1'b0, 1'b0);
    wb(2, 32'h77, 1'b0, 32'h0);
    do_rst();
    idle();
    bus.rs1_id = 5'd2;
    bus.rs2_id = 5'd1;
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst                  = ($urandom_range(0, 99) == 0);
      bus.rdy              = ($urandom_range(0, 9) != 0);
      bus.alloc_en         = 1'($urandom_range(0, 1));
      bus.alloc_rd         = 5'($urandom);
      bus.alloc_is_br      = ($urandom_range(0, 3) == 0);
      bus.alloc_pred_taken = 1'($urandom_range(0, 1));
      bus.wb_en            = ($urandom_range(0, 4) < 3);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        bus.wb_tag = 5'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        bus.wb_tag = 5'($urandom_range(0, 31));
      bus.wb_value = $urandom;
      bus.wb_taken = 1'($urandom_range(0, 1));
      bus.wb_pc    = $urandom;
      bus.rs1_id   = 5'($urandom_range(0, 20));
      bus.rs2_id   = (q.size() > 0)
                   ? 5'(q[$urandom_range(0, q.size() - 1)].tag)
                   : 5'd0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
